// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for a compute unit's per-thread LSU interface.
//   Each thread owns a 1-deep request slot driven by a small FSM
//   (IDLE -> PEND_RD/PEND_WR -> RRESP/WRESP -> IDLE). Pending slots are
//   granted round-robin onto a single-port data array, one access per cycle.
//   A host init port preloads the array and takes priority over all grants.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   read_req_*            per-thread load request (val/addr/rdy)
//   read_resp_*           per-thread load data (val/data/rdy)
//   write_req_*           per-thread store request (val/addr/data/rdy)
//   write_resp_val        per-thread one-cycle store-complete pulse
//   init_wen/addr/data    host preload write port
module data_mem_responder #(
  parameter int NUM_THREADS     = 4,
  parameter int DATA_WIDTH      = 16,
  parameter int DATA_ADDR_WIDTH = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_THREADS-1:0]                 read_req_addr_val,
  input  logic [NUM_THREADS*DATA_ADDR_WIDTH-1:0] read_req_addr,
  output logic [NUM_THREADS-1:0]                 read_req_rdy,
  output logic [NUM_THREADS-1:0]                 read_resp_data_val,
  output logic [NUM_THREADS*DATA_WIDTH-1:0]      read_resp_data,
  input  logic [NUM_THREADS-1:0]                 read_resp_rdy,
  input  logic [NUM_THREADS-1:0]                 write_req_val,
  input  logic [NUM_THREADS*DATA_ADDR_WIDTH-1:0] write_req_addr,
  input  logic [NUM_THREADS*DATA_WIDTH-1:0]      write_req_data,
  output logic [NUM_THREADS-1:0]                 write_req_rdy,
  output logic [NUM_THREADS-1:0]                 write_resp_val,
  input  logic                                   init_wen,
  input  logic [DATA_ADDR_WIDTH-1:0]             init_addr,
  input  logic [DATA_WIDTH-1:0]                  init_data
);

  localparam int PTR_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int DEPTH = 2 ** DATA_ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PEND_RD = 3'd1,
    ST_PEND_WR = 3'd2,
    ST_RRESP   = 3'd3,
    ST_WRESP   = 3'd4
  } state_t;

  logic [DATA_WIDTH-1:0]      r_mem [DEPTH];
  logic [DATA_WIDTH-1:0]      r_rdata [NUM_THREADS];
  logic [PTR_W-1:0]           r_rr_ptr;

  state_t                     w_state [NUM_THREADS];
  logic [DATA_ADDR_WIDTH-1:0] w_addr [NUM_THREADS];
  logic [DATA_WIDTH-1:0]      w_wdata [NUM_THREADS];
  logic [NUM_THREADS-1:0]     w_pend;
  logic [NUM_THREADS-1:0]     w_grant;

  logic                       w_arb_en;
  logic                       w_grant_any;
  logic [PTR_W-1:0]           w_grant_idx;
  logic                       w_grant_is_wr;
  logic [PTR_W:0]             w_ptr_inc;
  logic [PTR_W-1:0]           w_ptr_next;

  logic                       w_mem_we;
  logic [DATA_ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0]      w_mem_wdata;

  // Host preload owns the array port outright, so no thread is granted
  // while init_wen is high; nothing is granted during reset either.
  assign w_arb_en = !init_wen && !reset;

  // Rotating-priority scan starting at r_rr_ptr.
  always_comb begin
    logic [PTR_W:0] v_sum;
    v_sum       = '0;
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < NUM_THREADS; k++) begin
      v_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (v_sum >= (PTR_W+1)'(NUM_THREADS)) begin
        v_sum = v_sum - (PTR_W+1)'(NUM_THREADS);
      end
      if (w_arb_en && !w_grant_any && w_pend[v_sum[PTR_W-1:0]]) begin
        w_grant_any = 1'b1;
        w_grant_idx = v_sum[PTR_W-1:0];
      end
    end
  end

  assign w_grant_is_wr = (w_state[w_grant_idx] == ST_PEND_WR);
  assign w_ptr_inc     = {1'b0, w_grant_idx} + (PTR_W+1)'(1);
  assign w_ptr_next    = (w_ptr_inc >= (PTR_W+1)'(NUM_THREADS)) ? '0 : w_ptr_inc[PTR_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_grant_any) begin
      r_rr_ptr <= w_ptr_next;
    end
  end

  // Single array port: preload first, otherwise the granted store.
  always_comb begin
    if (init_wen) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = init_addr;
      w_mem_wdata = init_data;
    end else begin
      w_mem_we    = w_grant_any && w_grant_is_wr;
      w_mem_addr  = w_addr[w_grant_idx];
      w_mem_wdata = w_wdata[w_grant_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // Registered read lands directly in the granted thread's response slice
  // and stays there until that thread is granted another load.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        r_rdata[i] <= '0;
      end
    end else if (w_grant_any && !w_grant_is_wr) begin
      r_rdata[w_grant_idx] <= r_mem[w_addr[w_grant_idx]];
    end
  end

  for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_thread
    state_t                     r_state;
    state_t                     w_state_next;
    logic [DATA_ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]      r_wdata;
    logic                       w_rd_rdy;
    logic                       w_wr_rdy;
    logic                       w_rd_val;
    logic                       w_wr_val;
    logic                       w_rd_acc;
    logic                       w_wr_acc;

    assign w_grant[gi] = w_grant_any && (w_grant_idx == PTR_W'(gi));
    assign w_pend[gi]  = (r_state == ST_PEND_RD) || (r_state == ST_PEND_WR);
    assign w_rd_acc    = w_rd_rdy && read_req_addr_val[gi];
    assign w_wr_acc    = w_wr_rdy && write_req_val[gi];

    // State register
    always_ff @(posedge clk) begin
      if (reset) begin
        r_state <= ST_IDLE;
      end else begin
        r_state <= w_state_next;
      end
    end

    // Next-state logic
    always_comb begin
      w_state_next = r_state;
      case (r_state)
        ST_IDLE: begin
          if (w_rd_acc) begin
            w_state_next = ST_PEND_RD;
          end else if (w_wr_acc) begin
            w_state_next = ST_PEND_WR;
          end
        end
        ST_PEND_RD: if (w_grant[gi]) w_state_next = ST_RRESP;
        ST_PEND_WR: if (w_grant[gi]) w_state_next = ST_WRESP;
        ST_RRESP:   if (read_resp_rdy[gi]) w_state_next = ST_IDLE;
        ST_WRESP:   w_state_next = ST_IDLE;
        default:    w_state_next = ST_IDLE;
      endcase
    end

    // Outputs; held low while reset is asserted. A load on the same
    // cycle masks the store's ready so the requester keeps holding it.
    always_comb begin
      w_rd_rdy = 1'b0;
      w_wr_rdy = 1'b0;
      w_rd_val = 1'b0;
      w_wr_val = 1'b0;
      if (!reset) begin
        case (r_state)
          ST_IDLE: begin
            w_rd_rdy = 1'b1;
            w_wr_rdy = !read_req_addr_val[gi];
          end
          ST_RRESP: w_rd_val = 1'b1;
          ST_WRESP: w_wr_val = 1'b1;
          default: ;
        endcase
      end
    end

    // Slot capture
    always_ff @(posedge clk) begin
      if (w_rd_acc) begin
        r_addr <= read_req_addr[gi*DATA_ADDR_WIDTH +: DATA_ADDR_WIDTH];
      end else if (w_wr_acc) begin
        r_addr  <= write_req_addr[gi*DATA_ADDR_WIDTH +: DATA_ADDR_WIDTH];
        r_wdata <= write_req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    assign w_state[gi] = r_state;
    assign w_addr[gi]  = r_addr;
    assign w_wdata[gi] = r_wdata;

    assign read_req_rdy[gi]       = w_rd_rdy;
    assign write_req_rdy[gi]      = w_wr_rdy;
    assign read_resp_data_val[gi] = w_rd_val;
    assign write_resp_val[gi]     = w_wr_val;
    assign read_resp_data[gi*DATA_WIDTH +: DATA_WIDTH] = r_rdata[gi];
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: table of single-thread transactions,
// plus hand-written sequences for arbitration order, response stall,
// read/write collision, init preemption and reset mid-transaction.
// Load data and store completions are checked by a per-thread scoreboard.
module tb_data_mem_responder;

  localparam int NT = 4;
  localparam int DW = 16;
  localparam int AW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [NT-1:0]    read_req_addr_val, read_req_rdy, read_resp_data_val, read_resp_rdy;
  logic [NT-1:0]    write_req_val, write_req_rdy, write_resp_val;
  logic [NT*AW-1:0] read_req_addr, write_req_addr;
  logic [NT*DW-1:0] read_resp_data, write_req_data;
  logic             init_wen;
  logic [AW-1:0]    init_addr;
  logic [DW-1:0]    init_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_rd_q [NT][$];
  int            exp_wr_q [NT][$];

  typedef struct {
    int            t;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs [10];

  data_mem_responder #(.NUM_THREADS(NT), .DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW)) dut (
    .clk                (clk),
    .reset              (reset),
    .read_req_addr_val  (read_req_addr_val),
    .read_req_addr      (read_req_addr),
    .read_req_rdy       (read_req_rdy),
    .read_resp_data_val (read_resp_data_val),
    .read_resp_data     (read_resp_data),
    .read_resp_rdy      (read_resp_rdy),
    .write_req_val      (write_req_val),
    .write_req_addr     (write_req_addr),
    .write_req_data     (write_req_data),
    .write_req_rdy      (write_req_rdy),
    .write_resp_val     (write_resp_val),
    .init_wen           (init_wen),
    .init_addr          (init_addr),
    .init_data          (init_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input logic [AW-1:0] a, input logic [DW-1:0] d);
    init_wen  = 1'b1;
    init_addr = a;
    init_data = d;
    tick();
    init_wen  = 1'b0;
  endtask

  // One isolated transaction on thread t; checks accept, latency and release.
  task automatic do_txn(input int t, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] e, input string nm);
    int lat;
    if (wr) begin
      write_req_val[t] = 1'b1;
      write_req_addr[t*AW +: AW] = a;
      write_req_data[t*DW +: DW] = d;
    end else begin
      read_req_addr_val[t] = 1'b1;
      read_req_addr[t*AW +: AW] = a;
    end
    #1;
    check({nm, "_req_rdy"}, wr ? write_req_rdy[t] : read_req_rdy[t], 1);
    tick();
    write_req_val[t]     = 1'b0;
    read_req_addr_val[t] = 1'b0;
    if (wr) exp_wr_q[t].push_back(1);
    else    exp_rd_q[t].push_back(e);
    lat = 0;
    while (!(wr ? write_resp_val[t] : read_resp_data_val[t]) && lat < 20) begin
      tick();
      lat++;
    end
    check({nm, "_latency"}, lat, 1);
    if (wr) begin
      check({nm, "_busy_wrdy"}, write_req_rdy[t], 0);
      tick();
      check({nm, "_wresp_pulse_end"}, write_resp_val[t], 0);
      check({nm, "_wrdy_back"}, write_req_rdy[t], 1);
    end else begin
      check({nm, "_busy_rrdy"}, read_req_rdy[t], 0);
      tick();
      check({nm, "_rval_drop"}, read_resp_data_val[t], 0);
      check({nm, "_rrdy_back"}, read_req_rdy[t], 1);
    end
  endtask

  // Scoreboard: pop on every completed load handshake and every store pulse.
  always @(negedge clk) begin
    logic [DW-1:0] e_v;
    for (int i = 0; i < NT; i++) begin
      if (read_resp_data_val[i] && read_resp_rdy[i]) begin
        check($sformatf("rd_resp_expected_t%0d", i), exp_rd_q[i].size() != 0, 1);
        if (exp_rd_q[i].size() != 0) begin
          e_v = exp_rd_q[i].pop_front();
          check($sformatf("rd_data_t%0d", i), read_resp_data[i*DW +: DW], e_v);
        end
        $display("t=%0t load  resp thread %0d data %h", $time, i, read_resp_data[i*DW +: DW]);
      end
      if (write_resp_val[i]) begin
        check($sformatf("wr_resp_expected_t%0d", i), exp_wr_q[i].size() != 0, 1);
        if (exp_wr_q[i].size() != 0) void'(exp_wr_q[i].pop_front());
        $display("t=%0t store resp thread %0d", $time, i);
      end
    end
  end

  initial begin
    vecs[0] = '{0, 1'b0, 8'h10, 16'h0000, 16'h1234};
    vecs[1] = '{1, 1'b0, 8'h11, 16'h0000, 16'hBEEF};
    vecs[2] = '{2, 1'b1, 8'h20, 16'hA5A5, 16'h0000};
    vecs[3] = '{2, 1'b0, 8'h20, 16'h0000, 16'hA5A5};
    vecs[4] = '{0, 1'b1, 8'h00, 16'h7777, 16'h0000};
    vecs[5] = '{1, 1'b0, 8'h00, 16'h0000, 16'h7777};
    vecs[6] = '{0, 1'b1, 8'h10, 16'h5555, 16'h0000};
    vecs[7] = '{2, 1'b0, 8'h10, 16'h0000, 16'h5555};
    vecs[8] = '{3, 1'b1, 8'hFF, 16'h0F0F, 16'h0000};
    vecs[9] = '{3, 1'b0, 8'hFF, 16'h0000, 16'h0F0F};

    reset = 1'b1;
    read_req_addr_val = '0; read_req_addr = '0; read_resp_rdy = '1;
    write_req_val = '0; write_req_addr = '0; write_req_data = '0;
    init_wen = 1'b0; init_addr = '0; init_data = '0;
    repeat (3) tick();
    check("rst_read_req_rdy", read_req_rdy, 0);
    check("rst_write_req_rdy", write_req_rdy, 0);
    check("rst_read_resp_val", read_resp_data_val, 0);
    check("rst_write_resp_val", write_resp_val, 0);
    check("rst_read_resp_data", read_resp_data, 0);
    reset = 1'b0;
    #1;
    check("post_rst_read_rdy", read_req_rdy, 4'hF);
    check("post_rst_write_rdy", write_req_rdy, 4'hF);
    #3;

    do_init(8'h10, 16'h1234);
    do_init(8'h11, 16'hBEEF);
    for (int i = 0; i < NT; i++) do_init(AW'(8'h30 + i), DW'(16'hC000 + i));
    do_init(8'h60, 16'h0000);

    for (int v = 0; v < 10; v++)
      do_txn(vecs[v].t, vecs[v].wr, vecs[v].addr, vecs[v].data, vecs[v].exp, $sformatf("vec%0d", v));

    // All four threads load together with rr_ptr at 0.
    read_req_addr_val = 4'hF;
    for (int i = 0; i < NT; i++) read_req_addr[i*AW +: AW] = AW'(8'h30 + i);
    #1;
    check("all4_req_rdy", read_req_rdy, 4'hF);
    tick();
    read_req_addr_val = '0;
    for (int i = 0; i < NT; i++) exp_rd_q[i].push_back(DW'(16'hC000 + i));
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("all4_order_c%0d", k), read_resp_data_val, (k < 4) ? (32'd1 << k) : 32'd0);
    end

    // Thread 1 stalls its response while threads 0 and 2 are served.
    read_resp_rdy[1] = 1'b0;
    read_req_addr_val = 4'b0111;
    read_req_addr[0*AW +: AW] = 8'h30;
    read_req_addr[1*AW +: AW] = 8'h11;
    read_req_addr[2*AW +: AW] = 8'h32;
    #1;
    tick();
    read_req_addr_val = '0;
    exp_rd_q[0].push_back(16'hC000);
    exp_rd_q[1].push_back(16'hBEEF);
    exp_rd_q[2].push_back(16'hC002);
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) check("stall_t0_first", read_resp_data_val, 4'b0001);
      if (k >= 2 && k <= 6) begin
        check($sformatf("stall_val_c%0d", k), read_resp_data_val[1], 1);
        check($sformatf("stall_data_c%0d", k), read_resp_data[1*DW +: DW], 16'hBEEF);
        check($sformatf("stall_rrdy_c%0d", k), read_req_rdy[1], 0);
      end
      if (k == 3) check("stall_t2_served", read_resp_data_val[2], 1);
      if (k == 6) read_resp_rdy[1] = 1'b1;
      if (k == 7) begin
        check("stall_release_val", read_resp_data_val[1], 0);
        check("stall_release_rrdy", read_req_rdy[1], 1);
      end
    end

    // Thread 3 raises load and store together: load wins, store waits.
    read_req_addr_val[3] = 1'b1;
    read_req_addr[3*AW +: AW] = 8'h31;
    write_req_val[3] = 1'b1;
    write_req_addr[3*AW +: AW] = 8'h40;
    write_req_data[3*DW +: DW] = 16'h1111;
    #1;
    check("rw_wrdy_masked", write_req_rdy[3], 0);
    check("rw_rrdy", read_req_rdy[3], 1);
    tick();
    read_req_addr_val[3] = 1'b0;
    exp_rd_q[3].push_back(16'hC001);
    check("rw_wrdy_pend", write_req_rdy[3], 0);
    tick();
    check("rw_rval", read_resp_data_val[3], 1);
    check("rw_wrdy_rresp", write_req_rdy[3], 0);
    tick();
    check("rw_wrdy_idle", write_req_rdy[3], 1);
    tick();
    write_req_val[3] = 1'b0;
    exp_wr_q[3].push_back(1);
    check("rw_wresp_not_yet", write_resp_val[3], 0);
    tick();
    check("rw_wresp_pulse", write_resp_val[3], 1);
    tick();
    check("rw_wresp_end", write_resp_val[3], 0);
    do_txn(3, 1'b0, 8'h40, 16'h0000, 16'h1111, "rw_readback");

    // Move rr_ptr to 2, then hold init for 3 cycles over two pending loads.
    do_txn(1, 1'b0, 8'h11, 16'h0000, 16'hBEEF, "ptr_setup");
    read_req_addr_val = 4'b1001;
    read_req_addr[0*AW +: AW] = 8'h30;
    read_req_addr[3*AW +: AW] = 8'h33;
    #1;
    tick();
    read_req_addr_val = '0;
    exp_rd_q[0].push_back(16'hC000);
    exp_rd_q[3].push_back(16'hC003);
    for (int k = 0; k < 3; k++) begin
      init_wen  = 1'b1;
      init_addr = AW'(8'h50 + k);
      init_data = DW'(16'h2222 + k);
      tick();
      check($sformatf("init_block_c%0d", k), read_resp_data_val, 0);
    end
    init_wen = 1'b0;
    tick();
    check("init_resume_t3", read_resp_data_val, 4'b1000);
    tick();
    check("init_resume_t0", read_resp_data_val, 4'b0001);
    tick();
    check("init_resume_done", read_resp_data_val, 0);
    do_txn(2, 1'b0, 8'h52, 16'h0000, 16'h2224, "init_readback");

    // Reset while thread 0 holds a pending store.
    write_req_val[0] = 1'b1;
    write_req_addr[0*AW +: AW] = 8'h60;
    write_req_data[0*DW +: DW] = 16'h9999;
    #1;
    tick();
    write_req_val[0] = 1'b0;
    reset = 1'b1;
    tick();
    check("mid_rst_read_rdy", read_req_rdy, 0);
    check("mid_rst_write_rdy", write_req_rdy, 0);
    check("mid_rst_rval", read_resp_data_val, 0);
    check("mid_rst_wresp", write_resp_val, 0);
    check("mid_rst_rdata", read_resp_data, 0);
    reset = 1'b0;
    #1;
    check("mid_rst_release_rdy", read_req_rdy, 4'hF);
    do_txn(0, 1'b0, 8'h60, 16'h0000, 16'h0000, "rst_no_write");
    do_txn(2, 1'b0, 8'h20, 16'h0000, 16'hA5A5, "rst_store_kept");

    repeat (3) tick();
    for (int i = 0; i < NT; i++) begin
      check($sformatf("sb_rd_empty_t%0d", i), exp_rd_q[i].size(), 0);
      check($sformatf("sb_wr_empty_t%0d", i), exp_wr_q[i].size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the compute unit's per-thread LSU load/store interface.
- Captures at most one outstanding request per thread in a 1-deep slot.
- Arbitrates round-robin across threads onto a single-port, one-access-per-cycle data array.
- Returns load data with a val/rdy handshake and store completion as a one-cycle write_resp_val pulse; a host init port preloads the array.

Parameters:
NUM_THREADS, 4, number of thread channels served
DATA_WIDTH, 16, data word width
DATA_ADDR_WIDTH, 8, word address width; array depth = 2**DATA_ADDR_WIDTH

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
read_req_addr_val  in  NUM_THREADS  per-thread load request valid (bit i = thread i)
read_req_addr  in  NUM_THREADS*DATA_ADDR_WIDTH  load address, thread i at [i*DATA_ADDR_WIDTH +: DATA_ADDR_WIDTH]
read_req_rdy  out  NUM_THREADS  load request accept
read_resp_data_val  out  NUM_THREADS  load data valid
read_resp_data  out  NUM_THREADS*DATA_WIDTH  load data, thread i at [i*DATA_WIDTH +: DATA_WIDTH]
read_resp_rdy  in  NUM_THREADS  thread ready to take load data
write_req_val  in  NUM_THREADS  store request valid
write_req_addr  in  NUM_THREADS*DATA_ADDR_WIDTH  store address
write_req_data  in  NUM_THREADS*DATA_WIDTH  store data
write_req_rdy  out  NUM_THREADS  store request accept
write_resp_val  out  NUM_THREADS  one-cycle store-complete pulse
init_wen  in  1  host preload write enable
init_addr  in  DATA_ADDR_WIDTH  host preload address
init_data  in  DATA_WIDTH  host preload data

Behaviour:
- One clock; reset is synchronous and active-high on port reset.
- Reset:
  - All per-thread FSMs go to IDLE and rr_ptr goes to 0.
  - All outputs reset to 0: read_req_rdy, write_req_rdy, read_resp_data_val, write_resp_val, read_resp_data.
  - Array contents are not cleared.
  - Reset mid-transaction discards pending slots with no response and no array write. A store already written before reset stays written.
- Per-thread FSM states: IDLE, PEND_RD, PEND_WR, RRESP, WRESP.
- Ready rules:
  - read_req_rdy[i] = (state==IDLE).
  - write_req_rdy[i] = (state==IDLE) && !read_req_addr_val[i].
  - Read wins a same-cycle read+write on one thread; the write is not accepted and must be held by the requester.
- Capture:
  - IDLE with an accepted handshake: latch addr (and data for stores), go to PEND_RD or PEND_WR.
  - A new request cannot be captured in the cycle a slot frees; rdy rises the cycle after return to IDLE.
- Arbitration:
  - Each cycle, grant at most one PEND_* thread: first pending index scanning cyclically from rr_ptr.
  - On grant, rr_ptr <= (grant+1) mod NUM_THREADS; with no grant, rr_ptr holds.
  - init_wen=1 preempts: no grant that cycle, and the array is written with init_data at init_addr.
- Read grant:
  - At the clock edge the array word is registered into the thread's read_resp_data slice; state goes to RRESP.
  - read_resp_data_val[i]=1 in RRESP.
  - Data and val are held stable until read_resp_rdy[i]=1, then the thread returns to IDLE next cycle.
  - Minimum load latency: accept at edge N, grant in cycle N+1, val visible cycle N+2.
- Write grant:
  - The array is written at the edge; state goes to WRESP for exactly one cycle with write_resp_val[i]=1, then IDLE.
  - No backpressure on the write response.
- Ordering:
  - Accesses are serialized by grant order.
  - A read granted after a write to the same address returns the new data.
  - A read granted in the same cycle as an init write to its address is impossible, since init blocks grants.
- read_resp_data slices not in RRESP keep their last value; they are don't-care to consumers.
- Addresses use the full DATA_ADDR_WIDTH with no wrap or bounds check.
- Fairness: with all threads continuously pending, each thread is granted once every NUM_THREADS cycles.

Test Plan:
- Reset, then init writes addr 0x10=0x1234, 0x11=0xBEEF; thread 0 loads 0x10 with read_resp_rdy=1 -> read_resp_data_val[0] two cycles after accept with data 0x1234, rdy[0] high again after return to IDLE.
- Thread 2 stores 0xA5A5 to 0x20, then loads 0x20 -> write_resp_val[2] pulses exactly one cycle; load returns 0xA5A5.
- All 4 threads load distinct preloaded addresses in the same cycle with rr_ptr=0 -> responses appear in order thread 0,1,2,3 on consecutive cycles; rr_ptr ends at 0.
- Thread 1 holds read_resp_rdy=0 for 5 cycles -> val/data stay stable; read_req_rdy[1] stays 0; other threads keep being served.
- Thread 3 asserts read and write val together -> write_req_rdy[3]=0, read captured; the write is accepted after the read completes.
- init_wen held high for 3 cycles while threads are pending -> no grants during those cycles; arbitration resumes from the unchanged rr_ptr; reset asserted while a thread is in PEND_WR -> no array write and all outputs are 0 next cycle.
